// File: rtl/freq_meter_pkg.sv
// ============================================================================
// Module   : freq_meter_pkg
// Brief    : Shared state encoding and defaults for the frequency meter control.
// Revision : 1.0
// ============================================================================
`default_nettype none

package freq_meter_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      CLEAR = 2'd1,
      GATE  = 2'd2,
      LATCH = 2'd3
   } state_t;

   localparam int unsigned c_default_gate_cycles = 1000;
   localparam int unsigned c_default_timer_w     = 10;

endpackage

`default_nettype wire

// File: rtl/freq_meter_ctrl_edge_sync.sv
// ============================================================================
// Module   : edge_sync
// Brief    : Two-flop synchroniser plus history flop; one-cycle rising-edge pulse.
// Revision : 1.0
// ============================================================================
`default_nettype none

module edge_sync (
   input  logic clk,
   input  logic rst,
   input  logic sig_in,
   output logic rise
);

   logic r_s1;
   logic r_s2;
   logic r_s3;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_s1 <= 1'b0;
         r_s2 <= 1'b0;
         r_s3 <= 1'b0;
      end else begin
         r_s1 <= sig_in;
         r_s2 <= r_s1;
         r_s3 <= r_s2;
      end
   end

   assign rise = r_s2 & ~r_s3;

endmodule

`default_nettype wire

// File: rtl/freq_meter_ctrl.sv
// ============================================================================
// Module   : freq_meter_ctrl
// Brief    : Gate-window controller turning a 3-digit BCD counter into a frequency meter.
// Revision : 1.0
// ============================================================================
`default_nettype none

module freq_meter_ctrl
   import freq_meter_pkg::*;
#(
   parameter int unsigned GATE_CYCLES = c_default_gate_cycles,
   parameter int unsigned TIMER_W     = c_default_timer_w
) (
   input  logic clk,
   input  logic rst,
   input  logic run,
   input  logic sig_in,
   input  logic enb_machine,
   output logic cnt_enable,
   output logic cnt_ld,
   output logic cnt_rst,
   output logic gate,
   output logic meas_done,
   output logic overflow
);

   localparam logic [TIMER_W-1:0] c_timer_last = TIMER_W'(GATE_CYCLES - 1);

   state_t               r_state;
   state_t               w_state_nxt;
   logic [TIMER_W-1:0]   r_timer;
   logic                 r_ovf_acc;
   logic                 r_overflow;
   logic                 r_meas_done;
   logic                 w_rise;

   edge_sync u_edge_sync (
      .clk    (clk),
      .rst    (rst),
      .sig_in (sig_in),
      .rise   (w_rise)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Dropping run inside the window aborts before the timer check, so an
   // aborted window never reaches LATCH.
   always_comb begin
      w_state_nxt = r_state;
      cnt_enable  = 1'b0;
      cnt_ld      = 1'b0;
      cnt_rst     = 1'b0;
      gate        = 1'b0;
      case (r_state)
         IDLE: begin
            cnt_rst = 1'b1;
            if (run) w_state_nxt = CLEAR;
         end
         CLEAR: begin
            cnt_rst     = 1'b1;
            w_state_nxt = run ? GATE : IDLE;
         end
         GATE: begin
            gate       = 1'b1;
            cnt_enable = w_rise;
            if (!run) begin
               w_state_nxt = IDLE;
            end else if (r_timer == c_timer_last) begin
               w_state_nxt = LATCH;
            end
         end
         LATCH: begin
            cnt_ld      = 1'b1;
            w_state_nxt = run ? CLEAR : IDLE;
         end
         default: begin
            w_state_nxt = IDLE;
            cnt_rst     = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_timer   <= '0;
         r_ovf_acc <= 1'b0;
      end else begin
         case (r_state)
            CLEAR: begin
               r_timer   <= '0;
               r_ovf_acc <= 1'b0;
            end
            GATE: begin
               r_timer <= r_timer + TIMER_W'(1);
               // An edge counted while the chain reads 999 wraps it to 000.
               if (enb_machine && w_rise) r_ovf_acc <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_overflow  <= 1'b0;
         r_meas_done <= 1'b0;
      end else begin
         r_meas_done <= (r_state == LATCH);
         if (r_state == LATCH) r_overflow <= r_ovf_acc;
      end
   end

   assign meas_done = r_meas_done;
   assign overflow  = r_overflow;

endmodule

`default_nettype wire

// File: tb/tb_freq_meter_ctrl.sv
// ============================================================================
// Module   : tb_freq_meter_ctrl
// Brief    : Self-checking bench: directed scenarios plus randomized stimulus vs model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_freq_meter_ctrl;

   localparam int G = 20;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic run = 1'b0;
   logic sig_in = 1'b0;
   logic enb_machine = 1'b0;
   logic cnt_enable, cnt_ld, cnt_rst, gate, meas_done, overflow;

   freq_meter_ctrl #(
      .GATE_CYCLES (G),
      .TIMER_W     (5)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .run         (run),
      .sig_in      (sig_in),
      .enb_machine (enb_machine),
      .cnt_enable  (cnt_enable),
      .cnt_ld      (cnt_ld),
      .cnt_rst     (cnt_rst),
      .gate        (gate),
      .meas_done   (meas_done),
      .overflow    (overflow)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   // Model: position within a measurement (-1 idle, 0 clear, 1..G gate, G+1 latch)
   int   m_pos  = -1;
   logic [2:0] m_hist = 3'b000;   // sig_in seen at the last three edges, [0] newest
   logic m_acc  = 1'b0;
   logic m_ovf  = 1'b0;
   logic m_done = 1'b0;

   // Observed bookkeeping
   int cyc_n = 0;
   int en_total = 0;
   int gate_run = 0;
   int gate_len_last = 0;
   int ld_q[$];
   int en_at_ld[$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_checks++;
      if (obs !== exp_v) begin
         n_fail++;
         $display("FAIL %s cycle=%0d got=%0d expected=%0d", tag, cyc_n, obs, exp_v);
      end
   endtask

   task automatic model_edge();
      logic rise_now;
      logic in_gate;
      if (rst) begin
         m_pos = -1; m_hist = 3'b000; m_acc = 1'b0; m_ovf = 1'b0; m_done = 1'b0;
      end else begin
         rise_now = m_hist[1] & ~m_hist[2];
         in_gate  = (m_pos >= 1) && (m_pos <= G);
         m_done   = (m_pos == G + 1);
         if (m_pos == G + 1) m_ovf = m_acc;
         if (m_pos == 0) m_acc = 1'b0;
         else if (in_gate && enb_machine && rise_now) m_acc = 1'b1;
         if (m_pos == -1)     m_pos = run ? 0 : -1;
         else if (m_pos == 0) m_pos = run ? 1 : -1;
         else if (in_gate)    m_pos = !run ? -1 : m_pos + 1;
         else                 m_pos = run ? 0 : -1;
         m_hist = {m_hist[1:0], sig_in};
      end
   endtask

   task automatic cyc(input logic r, input logic rn, input logic s, input logic e);
      logic m_gate;
      rst = r; run = rn; sig_in = s; enb_machine = e;
      model_edge();
      @(negedge clk);
      cyc_n++;
      m_gate = (m_pos >= 1) && (m_pos <= G);
      chk("gate",       gate,       m_gate);
      chk("cnt_rst",    cnt_rst,    m_pos <= 0);
      chk("cnt_ld",     cnt_ld,     m_pos == G + 1);
      chk("cnt_enable", cnt_enable, m_gate & m_hist[1] & ~m_hist[2]);
      chk("meas_done",  meas_done,  m_done);
      chk("overflow",   overflow,   m_ovf);
      if (cnt_enable) en_total++;
      if (cnt_ld) begin
         ld_q.push_back(cyc_n);
         en_at_ld.push_back(en_total);
      end
      if (gate) gate_run++;
      else if (gate_run != 0) begin
         gate_len_last = gate_run;
         gate_run = 0;
      end
   endtask

   task automatic wait_ld(input int maxc, input logic s, input logic e);
      logic got;
      got = 1'b0;
      for (int i = 0; i < maxc && !got; i++) begin
         cyc(1'b0, 1'b1, s, e);
         got = cnt_ld;
      end
      chk("wait_ld", got, 1'b1);
   endtask

   logic rnd_run;
   logic rnd_sig;
   int   rnd_left;
   int   n_ld0, n_md0, en0;

   initial begin
      // 1: continuous run, period-4 input
      cyc(1'b1, 1'b0, 1'b0, 1'b0);
      chk("rst_cnt_rst", cnt_rst, 1'b1);
      chk("rst_gate", gate, 1'b0);
      cyc(1'b1, 1'b0, 1'b0, 1'b0);
      ld_q.delete(); en_at_ld.delete();
      for (int p = 0; p < 72; p++) cyc(1'b0, 1'b1, (p % 4) < 2, 1'b0);
      chk("t1_nld", ld_q.size() >= 3, 1'b1);
      if (ld_q.size() >= 3) begin
         chk("t1_period_a", ld_q[1] - ld_q[0], 22);
         chk("t1_period_b", ld_q[2] - ld_q[1], 22);
         chk("t1_edges_a", en_at_ld[1] - en_at_ld[0], 5);
         chk("t1_edges_b", en_at_ld[2] - en_at_ld[1], 5);
      end
      chk("t1_gate_len", gate_len_last, G);

      // 2: overflow set by a rise while enb_machine=1, cleared by a clean window
      wait_ld(30, 1'b0, 1'b0);
      for (int k = 0; k < 4; k++) cyc(1'b0, 1'b1, 1'b0, 1'b1);
      for (int k = 0; k < 3; k++) cyc(1'b0, 1'b1, 1'b1, 1'b1);
      wait_ld(30, 1'b0, 1'b1);
      cyc(1'b0, 1'b1, 1'b0, 1'b0);
      chk("t2_ovf_set", overflow, 1'b1);
      chk("t2_done", meas_done, 1'b1);
      wait_ld(30, 1'b0, 1'b0);
      cyc(1'b0, 1'b1, 1'b0, 1'b0);
      chk("t2_ovf_clr", overflow, 1'b0);

      // 3: abort at gate cycle 10
      for (int k = 0; k < 10; k++) cyc(1'b0, 1'b1, 1'b0, 1'b0);
      n_ld0 = ld_q.size();
      n_md0 = 0;
      cyc(1'b0, 1'b0, 1'b0, 1'b0);
      chk("t3_gate", gate, 1'b0);
      chk("t3_cnt_rst", cnt_rst, 1'b1);
      for (int k = 0; k < 25; k++) begin
         cyc(1'b0, 1'b0, 1'b0, 1'b0);
         if (meas_done) n_md0++;
      end
      chk("t3_no_ld", ld_q.size(), n_ld0);
      chk("t3_no_done", n_md0, 0);

      // 4: reset in gate cycle 5, then a full window
      for (int k = 0; k < 6; k++) cyc(1'b0, 1'b1, 1'b0, 1'b0);
      cyc(1'b1, 1'b1, 1'b0, 1'b0);
      chk("t4_cnt_rst", cnt_rst, 1'b1);
      chk("t4_gate", gate, 1'b0);
      chk("t4_ld", cnt_ld, 1'b0);
      wait_ld(40, 1'b0, 1'b0);
      chk("t4_gate_len", gate_len_last, G);

      // 5: rise in final gate cycle counts; rise in LATCH is dropped
      for (int k = 1; k <= 22; k++) begin
         cyc(1'b0, 1'b1, (k == 20) || (k == 21), 1'b0);
         if (k == 21) chk("t5_last_gate_en", {gate, cnt_enable}, 2'b11);
         if (k == 22) chk("t5_ld", cnt_ld, 1'b1);
      end
      for (int k = 1; k <= 22; k++) begin
         cyc(1'b0, 1'b1, (k >= 21), 1'b0);
         if (k == 22) chk("t5_latch_en", {cnt_ld, cnt_enable}, 2'b10);
      end

      // 6: long high input yields a single count
      en0 = en_total;
      for (int k = 1; k <= 60; k++) cyc(1'b0, 1'b1, (k >= 3) && (k <= 32), 1'b0);
      chk("t6_one_pulse", en_total - en0, 1);

      // Randomized run
      rnd_run = 1'b1; rnd_sig = 1'b0; rnd_left = 2;
      for (int k = 0; k < 1500; k++) begin
         if (rnd_left == 0) begin
            rnd_sig  = ~rnd_sig;
            rnd_left = $urandom_range(2, 7);
         end
         rnd_left--;
         if ($urandom_range(0, 59) == 0) rnd_run = ~rnd_run;
         cyc($urandom_range(0, 299) == 0, rnd_run, rnd_sig, $urandom_range(0, 7) == 0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
